// File: rtl/bram_transfer_ctrl.sv
// Moves operands A/B/N from the shared BRAM into the FIOS operand buffers (load)
// and copies the FIOS result buffer back into BRAM (store), handshaking with the top FSM.
module bram_transfer_ctrl #(
    parameter int WORD_WIDTH   = 17,
    parameter int NB_WORDS     = 16,
    parameter int ADDR_WIDTH   = 10,
    parameter int RES_BASE     = 48,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          mem_start_i,
    input  logic                          load_store_i,
    output logic                          load_done_o,
    output logic                          store_done_o,
    output logic                          bram_en_o,
    output logic                          bram_we_o,
    output logic [ADDR_WIDTH-1:0]         bram_addr_o,
    output logic [WORD_WIDTH-1:0]         bram_wdata_o,
    input  logic [WORD_WIDTH-1:0]         bram_rdata_i,
    output logic                          op_we_o,
    output logic [1:0]                    op_sel_o,
    output logic [$clog2(NB_WORDS)-1:0]   op_idx_o,
    output logic [WORD_WIDTH-1:0]         op_data_o,
    output logic                          res_rd_o,
    output logic [$clog2(NB_WORDS)-1:0]   res_addr_o,
    input  logic [WORD_WIDTH-1:0]         res_data_i
);
    localparam int IDX_W = $clog2(NB_WORDS);
    localparam int L     = BRAM_LATENCY;
    localparam logic [ADDR_WIDTH-1:0] LAST_RD    = ADDR_WIDTH'(3*NB_WORDS-1);
    localparam logic [ADDR_WIDTH-1:0] RES_BASE_A = ADDR_WIDTH'(RES_BASE);
    localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NB_WORDS-1);

    if (RES_BASE + NB_WORDS > (1 << ADDR_WIDTH)) begin : g_cfg_check
        $error("bram_transfer_ctrl: result window exceeds BRAM address space");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LOAD_FLUSH, S_STORE, S_STORE_FLUSH, S_RELEASE
    } state_t;

    state_t                  state_q;
    logic                    bram_en_q, bram_we_q;
    logic [ADDR_WIDTH-1:0]   bram_addr_q;
    logic                    res_rd_q;
    logic [IDX_W-1:0]        res_addr_q;
    logic                    op_we_q;
    logic [1:0]              op_sel_q;
    logic [IDX_W-1:0]        op_idx_q;
    logic [WORD_WIDTH-1:0]   op_data_q;
    logic                    load_done_q, store_done_q;
    logic [1:0]              rd_sel_q;
    logic [IDX_W-1:0]        rd_idx_q;

    // Tag pipeline follows each BRAM read until its data arrives.
    logic                    pv_q   [L];
    logic [1:0]              psel_q [L];
    logic [IDX_W-1:0]        pidx_q [L];
    logic                    plast_q[L];

    logic tag_vld_d, tag_last_d;
    assign tag_vld_d  = (state_q == S_LOAD);
    assign tag_last_d = (bram_addr_q == LAST_RD);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            bram_en_q    <= 1'b0;
            bram_we_q    <= 1'b0;
            bram_addr_q  <= '0;
            res_rd_q     <= 1'b0;
            res_addr_q   <= '0;
            op_we_q      <= 1'b0;
            op_sel_q     <= '0;
            op_idx_q     <= '0;
            op_data_q    <= '0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
            rd_sel_q     <= '0;
            rd_idx_q     <= '0;
            for (int i = 0; i < L; i++) begin
                pv_q[i]    <= 1'b0;
                psel_q[i]  <= '0;
                pidx_q[i]  <= '0;
                plast_q[i] <= 1'b0;
            end
        end else begin
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;

            pv_q[0]    <= tag_vld_d;
            psel_q[0]  <= rd_sel_q;
            pidx_q[0]  <= rd_idx_q;
            plast_q[0] <= tag_last_d;
            for (int i = 1; i < L; i++) begin
                pv_q[i]    <= pv_q[i-1];
                psel_q[i]  <= psel_q[i-1];
                pidx_q[i]  <= pidx_q[i-1];
                plast_q[i] <= plast_q[i-1];
            end

            op_we_q <= pv_q[L-1];
            if (pv_q[L-1]) begin
                op_sel_q  <= psel_q[L-1];
                op_idx_q  <= pidx_q[L-1];
                op_data_q <= bram_rdata_i;
            end

            case (state_q)
                S_IDLE: begin
                    if (mem_start_i) begin
                        if (load_store_i) begin
                            res_rd_q   <= 1'b1;
                            res_addr_q <= '0;
                            state_q    <= S_STORE;
                        end else begin
                            bram_en_q   <= 1'b1;
                            bram_addr_q <= '0;
                            rd_sel_q    <= '0;
                            rd_idx_q    <= '0;
                            state_q     <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (bram_addr_q == LAST_RD) begin
                        bram_en_q <= 1'b0;
                        state_q   <= S_LOAD_FLUSH;
                    end else begin
                        bram_addr_q <= bram_addr_q + ADDR_WIDTH'(1);
                        if (rd_idx_q == LAST_IDX) begin
                            rd_idx_q <= '0;
                            rd_sel_q <= rd_sel_q + 2'd1;
                        end else begin
                            rd_idx_q <= rd_idx_q + IDX_W'(1);
                        end
                    end
                end
                S_LOAD_FLUSH: begin
                    if (pv_q[L-1] && plast_q[L-1]) begin
                        load_done_q <= 1'b1;
                        state_q     <= S_RELEASE;
                    end
                end
                S_STORE: begin
                    // Word read this cycle is written to BRAM next cycle.
                    bram_en_q   <= 1'b1;
                    bram_we_q   <= 1'b1;
                    bram_addr_q <= RES_BASE_A + ADDR_WIDTH'(res_addr_q);
                    if (res_addr_q == LAST_IDX) begin
                        res_rd_q <= 1'b0;
                        state_q  <= S_STORE_FLUSH;
                    end else begin
                        res_addr_q <= res_addr_q + IDX_W'(1);
                    end
                end
                S_STORE_FLUSH: begin
                    bram_en_q    <= 1'b0;
                    bram_we_q    <= 1'b0;
                    store_done_q <= 1'b1;
                    state_q      <= S_RELEASE;
                end
                S_RELEASE: begin
                    if (!mem_start_i) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign load_done_o  = load_done_q;
    assign store_done_o = store_done_q;
    assign bram_en_o    = bram_en_q;
    assign bram_we_o    = bram_we_q;
    assign bram_addr_o  = bram_addr_q;
    // Result data arrives one cycle after the read strobe, aligned with the write cycle.
    assign bram_wdata_o = bram_we_q ? res_data_i : '0;
    assign op_we_o      = op_we_q;
    assign op_sel_o     = op_sel_q;
    assign op_idx_o     = op_idx_q;
    assign op_data_o    = op_data_q;
    assign res_rd_o     = res_rd_q;
    assign res_addr_o   = res_addr_q;
endmodule

// File: tb/tb_bram_transfer_ctrl.sv
// Bench for bram_transfer_ctrl: schedule-based reference model plus directed
// scenarios with hand-computed cycle/data expectations on two configurations.
module tb_bram_transfer_ctrl;
    localparam int N    = 4;
    localparam int L    = 2;
    localparam int RB   = 48;
    localparam int MAXC = 1024;

    logic clk, rst;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    // configuration 0: NB_WORDS=4, BRAM_LATENCY=2
    logic ms, ls, ld, sd, ben, bwe, opwe, resrd;
    logic [9:0]  baddr;
    logic [16:0] bwd, brd, opdata, resdata;
    logic [1:0]  opsel, opidx, resaddr;

    // configuration 1: NB_WORDS=2, BRAM_LATENCY=1
    logic ms1, ls1, ld1, sd1, ben1, bwe1, opwe1, resrd1;
    logic [9:0]  baddr1;
    logic [16:0] bwd1, brd1, opdata1, resdata1;
    logic [1:0]  opsel1;
    logic [0:0]  opidx1, resaddr1;

    bram_transfer_ctrl #(.WORD_WIDTH(17), .NB_WORDS(N), .ADDR_WIDTH(10), .RES_BASE(RB),
                         .BRAM_LATENCY(L)) dut (
        .clock_i(clk), .reset_i(rst), .mem_start_i(ms), .load_store_i(ls),
        .load_done_o(ld), .store_done_o(sd), .bram_en_o(ben), .bram_we_o(bwe),
        .bram_addr_o(baddr), .bram_wdata_o(bwd), .bram_rdata_i(brd),
        .op_we_o(opwe), .op_sel_o(opsel), .op_idx_o(opidx), .op_data_o(opdata),
        .res_rd_o(resrd), .res_addr_o(resaddr), .res_data_i(resdata));

    bram_transfer_ctrl #(.WORD_WIDTH(17), .NB_WORDS(2), .ADDR_WIDTH(10), .RES_BASE(RB),
                         .BRAM_LATENCY(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .mem_start_i(ms1), .load_store_i(ls1),
        .load_done_o(ld1), .store_done_o(sd1), .bram_en_o(ben1), .bram_we_o(bwe1),
        .bram_addr_o(baddr1), .bram_wdata_o(bwd1), .bram_rdata_i(brd1),
        .op_we_o(opwe1), .op_sel_o(opsel1), .op_idx_o(opidx1), .op_data_o(opdata1),
        .res_rd_o(resrd1), .res_addr_o(resaddr1), .res_data_i(resdata1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- environment: BRAMs and result buffer ----------------
    logic [16:0] wmem [0:1023];
    logic [16:0] resmem [4];
    logic [16:0] rpipe [L];
    logic [16:0] rp1;

    function automatic logic [16:0] rd_word(input logic [9:0] a);
        if (a < 10'd48) return 17'h100 + 17'(a);
        return wmem[a];
    endfunction

    always @(posedge clk) begin
        if (ben && bwe) wmem[baddr] <= bwd;
        rpipe[0] <= (ben && !bwe) ? rd_word(baddr) : 17'h1FFFF;
        rpipe[1] <= rpipe[0];
        resdata  <= resrd ? resmem[resaddr] : 17'h1FFFF;
        rp1      <= ben1 ? 17'h100 + 17'(baddr1) : 17'h1FFFF;
    end
    assign brd      = rpipe[L-1];
    assign brd1     = rp1;
    assign resdata1 = 17'h0;

    // ---------------- reference model: per-cycle expected outputs ----------------
    logic        exp_en [MAXC], exp_we [MAXC], exp_opwe [MAXC], exp_rr [MAXC];
    logic        exp_ld [MAXC], exp_sd [MAXC];
    logic [9:0]  exp_addr [MAXC];
    logic [16:0] exp_wd [MAXC], exp_od [MAXC];
    logic [1:0]  exp_sel [MAXC], exp_idx [MAXC], exp_ra [MAXC];
    bit          minit = 1'b0, m_busy = 1'b0;
    int          m_done = 0;

    task automatic clr(input int c);
        exp_en[c] <= 1'b0; exp_we[c] <= 1'b0; exp_opwe[c] <= 1'b0; exp_rr[c] <= 1'b0;
        exp_ld[c] <= 1'b0; exp_sd[c] <= 1'b0; exp_addr[c] <= '0; exp_wd[c] <= '0;
        exp_od[c] <= '0; exp_sel[c] <= '0; exp_idx[c] <= '0; exp_ra[c] <= '0;
    endtask

    // A transfer accepted at edge e fixes the outputs of every later cycle up to its done pulse.
    always @(posedge clk) begin
        if (!minit) begin
            for (int c = 0; c < MAXC; c++) clr(c);
            minit <= 1'b1;
        end else if (rst) begin
            for (int c = cyc + 1; c < cyc + 40 && c < MAXC; c++) clr(c);
            m_busy <= 1'b0;
        end else if (!m_busy) begin
            if (ms && cyc + 40 < MAXC) begin
                m_busy <= 1'b1;
                if (!ls) begin
                    for (int a = 0; a < 3*N; a++) begin
                        exp_en[cyc+1+a]     <= 1'b1;
                        exp_addr[cyc+1+a]   <= 10'(a);
                        exp_opwe[cyc+a+L+2] <= 1'b1;
                        exp_sel[cyc+a+L+2]  <= 2'(a / N);
                        exp_idx[cyc+a+L+2]  <= 2'(a % N);
                        exp_od[cyc+a+L+2]   <= 17'h100 + 17'(a);
                    end
                    exp_ld[cyc+3*N+L+1] <= 1'b1;
                    m_done <= cyc + 3*N + L + 1;
                end else begin
                    for (int i = 0; i < N; i++) begin
                        exp_rr[cyc+1+i]   <= 1'b1;
                        exp_ra[cyc+1+i]   <= 2'(i);
                        exp_en[cyc+2+i]   <= 1'b1;
                        exp_we[cyc+2+i]   <= 1'b1;
                        exp_addr[cyc+2+i] <= 10'(RB + i);
                        exp_wd[cyc+2+i]   <= resmem[i];
                    end
                    exp_sd[cyc+N+2] <= 1'b1;
                    m_done <= cyc + N + 2;
                end
            end
        end else if (cyc >= m_done && !ms) begin
            m_busy <= 1'b0;
        end
        cyc <= cyc + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (minit && cyc < MAXC) begin
            chk("bram_en", 64'(ben), 64'(exp_en[cyc]));
            chk("bram_we", 64'(bwe), 64'(exp_we[cyc]));
            if (exp_en[cyc]) chk("bram_addr", 64'(baddr), 64'(exp_addr[cyc]));
            if (exp_we[cyc]) chk("bram_wdata", 64'(bwd), 64'(exp_wd[cyc]));
            chk("op_we", 64'(opwe), 64'(exp_opwe[cyc]));
            if (exp_opwe[cyc]) begin
                chk("op_sel", 64'(opsel), 64'(exp_sel[cyc]));
                chk("op_idx", 64'(opidx), 64'(exp_idx[cyc]));
                chk("op_data", 64'(opdata), 64'(exp_od[cyc]));
            end
            chk("res_rd", 64'(resrd), 64'(exp_rr[cyc]));
            if (exp_rr[cyc]) chk("res_addr", 64'(resaddr), 64'(exp_ra[cyc]));
            chk("load_done", 64'(ld), 64'(exp_ld[cyc]));
            chk("store_done", 64'(sd), 64'(exp_sd[cyc]));
        end
    end

    // ---------------- event recorder for literal checks ----------------
    int          q_we[$], q_ld[$], q_sd[$], q_en[$], q_bw[$], q_rr[$], q1_we[$];
    logic [16:0] q_wd[$], q1_wd[$];
    logic [9:0]  q_ba[$];

    always @(negedge clk) begin
        if (opwe) begin q_we.push_back(cyc); q_wd.push_back(opdata); end
        if (ld) q_ld.push_back(cyc);
        if (sd) q_sd.push_back(cyc);
        if (ben) q_en.push_back(cyc);
        if (ben && bwe) begin q_bw.push_back(cyc); q_ba.push_back(baddr); end
        if (resrd) q_rr.push_back(cyc);
        if (opwe1) begin q1_we.push_back(cyc); q1_wd.push_back(opdata1); end
    end

    task automatic qclr();
        q_we.delete(); q_wd.delete(); q_ld.delete(); q_sd.delete(); q_en.delete();
        q_bw.delete(); q_ba.delete(); q_rr.delete(); q1_we.delete(); q1_wd.delete();
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // which: 0=load_done, 1=store_done, 2=load_done of config 1
    task automatic wait_done(input int which, output int d);
        d = -1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if ((which == 0 && ld) || (which == 1 && sd) || (which == 2 && ld1)) begin
                d = cyc;
                return;
            end
        end
        chk("done_timeout", 64'(0), 64'(1));
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({ld, sd, ben, bwe, baddr, bwd, opwe, opsel, opidx, opdata, resrd, resaddr});
    endfunction

    int s, d, d2;

    initial begin
        rst = 1'b1; ms = 1'b0; ls = 1'b0; ms1 = 1'b0; ls1 = 1'b0;
        resmem[0] = 17'h1A; resmem[1] = 17'h2B; resmem[2] = 17'h3C; resmem[3] = 17'h4D;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'(0));
        rst = 1'b0;
        tick();

        // load with request held high well after done
        qclr(); s = cyc; ms = 1'b1; ls = 1'b0;
        wait_done(0, d);
        chk("load_done_cycle", 64'(d), 64'(s + 15));
        repeat (20) tick();
        chk("load_we_count", 64'(q_we.size()), 64'(12));
        chk("load_first_we", 64'(q_we.size() > 0 ? q_we[0] : -1), 64'(s + 4));
        chk("load_last_data", 64'(q_wd.size() > 11 ? q_wd[11] : 17'h0), 64'(17'h10B));
        chk("load_done_count", 64'(q_ld.size()), 64'(1));
        chk("load_reads_held", 64'(q_en.size()), 64'(12));

        // drop, then store
        ms = 1'b0; tick(); tick();
        qclr(); s = cyc; ms = 1'b1; ls = 1'b1;
        wait_done(1, d);
        chk("store_done_cycle", 64'(d), 64'(s + 6));
        chk("store_first_write", 64'(q_bw.size() > 0 ? q_bw[0] : -1), 64'(s + 2));
        chk("store_first_addr", 64'(q_ba.size() > 0 ? q_ba[0] : 10'h0), 64'(48));
        chk("store_last_addr", 64'(q_ba.size() > 3 ? q_ba[3] : 10'h0), 64'(51));
        ms = 1'b0; tick(); tick();
        chk("bram_word49", 64'(wmem[49]), 64'(17'h2B));
        chk("bram_word51", 64'(wmem[51]), 64'(17'h4D));

        // reset during the third read of a load
        qclr(); s = cyc; ms = 1'b1; ls = 1'b0;
        repeat (3) tick();
        chk("reads_before_reset", 64'(q_en.size()), 64'(3));
        rst = 1'b1; ms = 1'b0;
        tick();
        chk("outputs_after_reset", all_outs(), 64'(0));
        rst = 1'b0;
        repeat (10) tick();
        chk("no_we_after_reset", 64'(q_we.size()), 64'(0));
        chk("no_done_after_reset", 64'(q_ld.size()), 64'(0));
        qclr(); s = cyc; ms = 1'b1;
        wait_done(0, d);
        chk("reload_done_cycle", 64'(d), 64'(s + 15));
        chk("reload_first_data", 64'(q_wd.size() > 0 ? q_wd[0] : 17'h0), 64'(17'h100));
        ms = 1'b0; tick(); tick();

        // request dropped and direction toggled mid-load
        qclr(); s = cyc; ms = 1'b1; ls = 1'b0;
        repeat (4) tick();
        ls = 1'b1; ms = 1'b0;
        wait_done(0, d);
        chk("toggle_load_done", 64'(d), 64'(s + 15));
        chk("toggle_we_count", 64'(q_we.size()), 64'(12));
        chk("toggle_no_store", 64'(q_bw.size()), 64'(0));
        tick();
        qclr(); ms = 1'b1; ls = 1'b1;
        wait_done(1, d2);
        chk("release_one_cycle", 64'(q_rr.size() > 0 ? q_rr[0] : -1), 64'(d + 2));
        chk("store_after_release", 64'(d2), 64'(d + 7));
        ms = 1'b0; tick(); tick();

        // NB_WORDS=2, BRAM_LATENCY=1 load
        qclr(); s = cyc; ms1 = 1'b1;
        wait_done(2, d);
        chk("cfg1_done_cycle", 64'(d), 64'(s + 8));
        chk("cfg1_first_we", 64'(q1_we.size() > 0 ? q1_we[0] : -1), 64'(s + 3));
        chk("cfg1_we_count", 64'(q1_we.size()), 64'(6));
        chk("cfg1_last_data", 64'(q1_wd.size() > 5 ? q1_wd[5] : 17'h0), 64'(17'h105));
        ms1 = 1'b0; tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
